// File: rtl/vga_text_writer.sv
// Character-stream writer for the vga_text video RAM port: cursor, CR/LF/BS handling, scrolling.
// Optional: define VGA_TEXT_WRITER_FF_CLEAR_EN so that 0x0C clears the screen and homes the cursor.
module vga_text_writer #(
  parameter int unsigned COLS  = 80,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        vclk,
  input  logic        rst,
  input  logic [7:0]  char_in,
  input  logic        char_valid,
  output logic        char_ready,
  output logic [11:0] vram_addr,
  output logic [7:0]  vram_dout,
  output logic        vram_we,
  input  logic [7:0]  vram_din,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  localparam logic [2:0] ST_CLEAR  = 3'd0;
  localparam logic [2:0] ST_IDLE   = 3'd1;
  localparam logic [2:0] ST_WRITE  = 3'd2;
  localparam logic [2:0] ST_SC_RD  = 3'd3;
  localparam logic [2:0] ST_SC_WR  = 3'd4;
  localparam logic [2:0] ST_SC_CLR = 3'd5;

  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [11:0] LAST     = 12'(COLS * ROWS - 1);
  localparam logic [11:0] CLR_BASE = 12'((ROWS - 1) * COLS);
  localparam logic [6:0]  COL_LAST = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST = 5'(ROWS - 1);

  logic [2:0]  state_q, state_d;
  logic [11:0] ptr_q, ptr_d;
  logic [11:0] line_base_q, line_base_d;
  logic [6:0]  col_q, col_d;
  logic [4:0]  row_q, row_d;
  logic [7:0]  char_q, char_d;
  logic        cr_hold_q, cr_hold_d;
  logic        accept;

  // A CR leaves the writer in IDLE but withholds ready for one cycle.
  assign char_ready = (state_q == ST_IDLE) && !cr_hold_q;
  assign accept     = char_ready && char_valid;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    line_base_d = line_base_q;
    col_d       = col_q;
    row_d       = row_q;
    char_d      = char_q;
    cr_hold_d   = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 12'd1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          case (char_in)
            8'h0D: begin
              col_d     = '0;
              cr_hold_d = 1'b1;
            end
            8'h0A: begin
              if (row_q != ROW_LAST) begin
                row_d       = row_q + 5'd1;
                line_base_d = line_base_q + COLS_W;
              end else begin
                state_d = ST_SC_RD;
                ptr_d   = COLS_W;
              end
            end
            8'h08: begin
              if (col_q != 7'd0) col_d = col_q - 7'd1;
            end
`ifdef VGA_TEXT_WRITER_FF_CLEAR_EN
            8'h0C: begin
              state_d     = ST_CLEAR;
              ptr_d       = '0;
              col_d       = '0;
              row_d       = '0;
              line_base_d = '0;
            end
`endif
            default: begin
              char_d  = char_in;
              state_d = ST_WRITE;
            end
          endcase
        end
      end
      ST_WRITE: begin
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q != ROW_LAST) begin
            row_d       = row_q + 5'd1;
            line_base_d = line_base_q + COLS_W;
            state_d     = ST_IDLE;
          end else begin
            state_d = ST_SC_RD;
            ptr_d   = COLS_W;
          end
        end else begin
          col_d   = col_q + 7'd1;
          state_d = ST_IDLE;
        end
      end
      ST_SC_RD: begin
        state_d = ST_SC_WR;
      end
      ST_SC_WR: begin
        if (ptr_q == LAST) begin
          state_d = ST_SC_CLR;
          ptr_d   = CLR_BASE;
        end else begin
          state_d = ST_SC_RD;
          ptr_d   = ptr_q + 12'd1;
        end
      end
      ST_SC_CLR: begin
        if (ptr_q == LAST) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 12'd1;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge vclk) begin
    if (rst) begin
      state_q     <= ST_CLEAR;
      ptr_q       <= '0;
      line_base_q <= '0;
      col_q       <= '0;
      row_q       <= '0;
      char_q      <= '0;
      cr_hold_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      line_base_q <= line_base_d;
      col_q       <= col_d;
      row_q       <= row_d;
      char_q      <= char_d;
      cr_hold_q   <= cr_hold_d;
    end
  end

  always_comb begin
    vram_we   = 1'b0;
    vram_addr = ptr_q;
    vram_dout = BLANK;
    busy      = 1'b0;
    case (state_q)
      ST_CLEAR, ST_SC_CLR: begin
        vram_we = 1'b1;
        busy    = 1'b1;
      end
      ST_WRITE: begin
        vram_we   = 1'b1;
        vram_addr = line_base_q + {5'd0, col_q};
        vram_dout = char_q;
      end
      ST_SC_RD: begin
        busy = 1'b1;
      end
      ST_SC_WR: begin
        // Source cell was read last cycle; write it one row up.
        vram_we   = 1'b1;
        vram_addr = ptr_q - COLS_W;
        vram_dout = vram_din;
        busy      = 1'b1;
      end
      default: begin
        vram_we = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Self-checking bench for vga_text_writer: RAM model, terminal-level screen reference model.
module tb_vga_text_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int NCELL = COLS * ROWS;

  logic        vclk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  char_in = 8'h00;
  logic        char_valid = 1'b0;
  logic        char_ready;
  logic [11:0] vram_addr;
  logic [7:0]  vram_dout;
  logic        vram_we;
  logic [7:0]  vram_din;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  vga_text_writer #(
    .COLS (COLS),
    .ROWS (ROWS),
    .BLANK(8'h20)
  ) dut (
    .vclk      (vclk),
    .rst       (rst),
    .char_in   (char_in),
    .char_valid(char_valid),
    .char_ready(char_ready),
    .vram_addr (vram_addr),
    .vram_dout (vram_dout),
    .vram_we   (vram_we),
    .vram_din  (vram_din),
    .cursor_col(cursor_col),
    .cursor_row(cursor_row),
    .busy      (busy)
  );

  always #5 vclk = ~vclk;

  // Synchronous video RAM as seen by the writer port.
  logic [7:0] mem [0:4095];
  always @(posedge vclk) begin
    if (vram_we === 1'b1) mem[vram_addr] <= vram_dout;
    vram_din <= mem[vram_addr];
  end

  int cyc = 0;
  int busy_cnt = 0;
  logic [11:0] wa_q[$];
  logic [7:0]  wd_q[$];

  always @(posedge vclk) cyc <= cyc + 1;

  always @(negedge vclk) begin
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (vram_we === 1'b1) begin
      wa_q.push_back(vram_addr);
      wd_q.push_back(vram_dout);
    end
  end

  int nvec = 0;
  int nfail = 0;

  // Reference terminal: screen contents and cursor derived from the character stream.
  logic [7:0] ref_scr [0:NCELL-1];
  int ref_col = 0;
  int ref_row = 0;

  function automatic void ref_clear();
    for (int i = 0; i < NCELL; i++) ref_scr[i] = 8'h20;
    ref_col = 0;
    ref_row = 0;
  endfunction

  function automatic void ref_lf();
    if (ref_row < ROWS - 1) begin
      ref_row++;
    end else begin
      for (int i = 0; i < NCELL - COLS; i++) ref_scr[i] = ref_scr[i + COLS];
      for (int i = NCELL - COLS; i < NCELL; i++) ref_scr[i] = 8'h20;
    end
  endfunction

  function automatic void ref_put(input logic [7:0] b);
    if (b == 8'h0D) begin
      ref_col = 0;
    end else if (b == 8'h0A) begin
      ref_lf();
    end else if (b == 8'h08) begin
      if (ref_col > 0) ref_col--;
`ifdef VGA_TEXT_WRITER_FF_CLEAR_EN
    end else if (b == 8'h0C) begin
      ref_clear();
`endif
    end else begin
      ref_scr[ref_row * COLS + ref_col] = b;
      ref_col++;
      if (ref_col == COLS) begin
        ref_col = 0;
        ref_lf();
      end
    end
  endfunction

  function automatic int scr_diffs(output int first);
    int n = 0;
    first = -1;
    for (int i = 0; i < NCELL; i++) begin
      if (mem[i] !== ref_scr[i]) begin
        if (first < 0) first = i;
        n++;
      end
    end
    return n;
  endfunction

  // Present a byte and wait until accepted; returns at the following negedge with valid still high.
  task automatic send(input logic [7:0] b, output int acc);
    logic rdy;
    bit got = 0;
    char_in = b;
    char_valid = 1'b1;
    for (int i = 0; i < 20000 && !got; i++) begin
      rdy = char_ready;
      @(posedge vclk);
      if (rdy === 1'b1) got = 1;
      @(negedge vclk);
    end
    acc = cyc;
    if (got) begin
      ref_put(b);
    end else begin
      nvec++;
      nfail++;
      $display("FAIL send_timeout: byte %02h not accepted, ready=%b, required acceptance", b,
               char_ready);
    end
  endtask

  task automatic put(input logic [7:0] b);
    int a;
    send(b, a);
    char_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      if (char_ready === 1'b1 && busy === 1'b0) ok = 1;
      else @(negedge vclk);
    end
    if (!ok) begin
      nvec++;
      nfail++;
      $display("FAIL %s_idle_timeout: busy=%b ready=%b, required idle", tag, busy, char_ready);
    end
  endtask

  task automatic do_reset();
    char_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge vclk);
    #1;
    rst = 1'b0;
    ref_clear();
    @(negedge vclk);
    wait_idle("reset");
  endtask

  task automatic test_reset();
    int wb, bb, bad;
    int hits[NCELL];
    char_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge vclk);
    #1;
    nvec++;
    if (char_ready !== 1'b0 || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      nfail++;
      $display("FAIL reset_state: ready=%b cursor=(%0d,%0d), required ready=0 cursor=(0,0)",
               char_ready, cursor_row, cursor_col);
    end
    // Release, then reassert part-way through the clear.
    rst = 1'b0;
    repeat (500) @(posedge vclk);
    #1;
    rst = 1'b1;
    @(posedge vclk);
    #1;
    rst = 1'b0;
    wb = wa_q.size();
    bb = busy_cnt;
    ref_clear();
    @(negedge vclk);
    wait_idle("clear");
    nvec++;
    if (busy_cnt - bb !== NCELL) begin
      nfail++;
      $display("FAIL clear_busy_cycles: got %0d, required %0d", busy_cnt - bb, NCELL);
    end
    for (int i = 0; i < NCELL; i++) hits[i] = 0;
    bad = 0;
    for (int k = wb; k < wa_q.size(); k++) begin
      if (int'(wa_q[k]) >= NCELL || wd_q[k] !== 8'h20) bad++;
      else if (hits[wa_q[k]] != 0) bad++;
      else hits[wa_q[k]] = 1;
    end
    nvec++;
    if (wa_q.size() - wb !== NCELL || bad !== 0) begin
      nfail++;
      $display("FAIL clear_writes: got %0d writes with %0d bad, required %0d unique blanks",
               wa_q.size() - wb, bad, NCELL);
    end
    nvec++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      nfail++;
      $display("FAIL clear_cursor: got (%0d,%0d), required (0,0)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_back_to_back();
    int a1, a2, wb;
    do_reset();
    wb = wa_q.size();
    send(8'h41, a1);
    send(8'h42, a2);
    char_valid = 1'b0;
    wait_idle("b2b");
    nvec++;
    if (a2 - a1 !== 2) begin
      nfail++;
      $display("FAIL b2b_spacing: got %0d cycles, required 2", a2 - a1);
    end
    nvec++;
    if (wa_q.size() - wb !== 2) begin
      nfail++;
      $display("FAIL b2b_write_count: got %0d, required 2", wa_q.size() - wb);
    end else if (wa_q[wb] !== 12'd0 || wd_q[wb] !== 8'h41 ||
                 wa_q[wb+1] !== 12'd1 || wd_q[wb+1] !== 8'h42) begin
      nfail++;
      $display("FAIL b2b_writes: got %02h@%0d %02h@%0d, required 41@0 42@1", wd_q[wb], wa_q[wb],
               wd_q[wb+1], wa_q[wb+1]);
    end
    nvec++;
    if (cursor_col !== 7'd2 || cursor_row !== 5'd0) begin
      nfail++;
      $display("FAIL b2b_cursor: got (%0d,%0d), required (0,2)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_cr_lf();
    int a, wb;
    do_reset();
    wb = wa_q.size();
    put(8'h58);
    send(8'h0D, a);
    nvec++;
    if (char_ready !== 1'b0) begin
      nfail++;
      $display("FAIL cr_ready_drop: got ready=%b after CR, required 0", char_ready);
    end
    char_valid = 1'b0;
    put(8'h0A);
    put(8'h59);
    wait_idle("crlf");
    nvec++;
    if (wa_q.size() - wb !== 2) begin
      nfail++;
      $display("FAIL crlf_write_count: got %0d, required 2", wa_q.size() - wb);
    end else if (wa_q[wb] !== 12'd0 || wd_q[wb] !== 8'h58 ||
                 wa_q[wb+1] !== 12'd80 || wd_q[wb+1] !== 8'h59) begin
      nfail++;
      $display("FAIL crlf_writes: got %02h@%0d %02h@%0d, required 58@0 59@80", wd_q[wb],
               wa_q[wb], wd_q[wb+1], wa_q[wb+1]);
    end
    nvec++;
    if (cursor_col !== 7'd1 || cursor_row !== 5'd1) begin
      nfail++;
      $display("FAIL crlf_cursor: got (%0d,%0d), required (1,1)", cursor_row, cursor_col);
    end
  endtask

  task automatic test_backspace();
    int wb;
    do_reset();
    wb = wa_q.size();
    put(8'h08);
    wait_idle("bs0");
    nvec++;
    if (wa_q.size() !== wb || cursor_col !== 7'd0 || cursor_row !== 5'd0) begin
      nfail++;
      $display("FAIL bs_at_col0: got %0d writes cursor=(%0d,%0d), required 0 writes (0,0)",
               wa_q.size() - wb, cursor_row, cursor_col);
    end
    put(8'h51);
    put(8'h08);
    put(8'h52);
    wait_idle("bs1");
    nvec++;
    if (wa_q.size() - wb !== 2) begin
      nfail++;
      $display("FAIL bs_write_count: got %0d, required 2", wa_q.size() - wb);
    end else if (wa_q[wb] !== 12'd0 || wd_q[wb] !== 8'h51 ||
                 wa_q[wb+1] !== 12'd0 || wd_q[wb+1] !== 8'h52) begin
      nfail++;
      $display("FAIL bs_writes: got %02h@%0d %02h@%0d, required 51@0 52@0", wd_q[wb], wa_q[wb],
               wd_q[wb+1], wa_q[wb+1]);
    end
    nvec++;
    if (mem[0] !== 8'h52 || cursor_col !== 7'd1) begin
      nfail++;
      $display("FAIL bs_result: got mem[0]=%02h col=%0d, required 52 and 1", mem[0], cursor_col);
    end
  endtask

  task automatic test_scroll();
    int wb, bb, nd, fi;
    logic [7:0] lastb;
    do_reset();
    for (int i = 0; i < 100; i++) put(8'($urandom_range(33, 126)));
    put(8'h0D);
    while (ref_row < ROWS - 1) put(8'h0A);
    for (int i = 0; i < COLS - 1; i++) put(8'($urandom_range(33, 126)));
    wait_idle("prescroll");
    wb = wa_q.size();
    bb = busy_cnt;
    lastb = 8'($urandom_range(33, 126));
    put(lastb);
    wait_idle("scroll");
    nvec++;
    if (wa_q.size() - wb !== 1 + NCELL) begin
      nfail++;
      $display("FAIL scroll_write_count: got %0d, required %0d", wa_q.size() - wb, 1 + NCELL);
    end else if (wa_q[wb] !== 12'(NCELL - 1) || wd_q[wb] !== lastb) begin
      nfail++;
      $display("FAIL scroll_last_cell: got %02h@%0d, required %02h@%0d", wd_q[wb], wa_q[wb],
               lastb, NCELL - 1);
    end
    nvec++;
    if (busy_cnt - bb !== 2 * (ROWS - 1) * COLS + COLS) begin
      nfail++;
      $display("FAIL scroll_busy_cycles: got %0d, required %0d", busy_cnt - bb,
               2 * (ROWS - 1) * COLS + COLS);
    end
    nd = scr_diffs(fi);
    nvec++;
    if (nd !== 0) begin
      nfail++;
      $display("FAIL scroll_screen: %0d cells differ, first @%0d got %02h required %02h", nd, fi,
               mem[fi], ref_scr[fi]);
    end
    nvec++;
    if (cursor_col !== 7'd0 || cursor_row !== 5'(ROWS - 1)) begin
      nfail++;
      $display("FAIL scroll_cursor: got (%0d,%0d), required (%0d,0)", cursor_row, cursor_col,
               ROWS - 1);
    end
  endtask

  task automatic test_form_feed();
    int wb, bb, nd, fi, bad;
    do_reset();
    repeat (5) put(8'h0A);
    for (int i = 0; i < 10; i++) put(8'($urandom_range(33, 126)));
    wait_idle("preff");
    wb = wa_q.size();
    bb = busy_cnt;
    put(8'h0C);
    wait_idle("ff");
`ifdef VGA_TEXT_WRITER_FF_CLEAR_EN
    bad = 0;
    for (int k = wb; k < wa_q.size(); k++) if (wd_q[k] !== 8'h20) bad++;
    nvec++;
    if (wa_q.size() - wb !== NCELL || bad !== 0 || busy_cnt - bb !== NCELL) begin
      nfail++;
      $display("FAIL ff_clear: got %0d writes (%0d non-blank), %0d busy, required %0d each",
               wa_q.size() - wb, bad, busy_cnt - bb, NCELL);
    end
`else
    bad = busy_cnt - bb;
    nvec++;
    if (wa_q.size() - wb !== 1 || bad !== 0) begin
      nfail++;
      $display("FAIL ff_write_count: got %0d writes %0d busy, required 1 write 0 busy",
               wa_q.size() - wb, bad);
    end else if (wa_q[wb] !== 12'd410 || wd_q[wb] !== 8'h0C) begin
      nfail++;
      $display("FAIL ff_write: got %02h@%0d, required 0c@410", wd_q[wb], wa_q[wb]);
    end
`endif
    nd = scr_diffs(fi);
    nvec++;
    if (nd !== 0) begin
      nfail++;
      $display("FAIL ff_screen: %0d cells differ, first @%0d got %02h required %02h", nd, fi,
               mem[fi], ref_scr[fi]);
    end
    nvec++;
    if (cursor_col !== 7'(ref_col) || cursor_row !== 5'(ref_row)) begin
      nfail++;
      $display("FAIL ff_cursor: got (%0d,%0d), required (%0d,%0d)", cursor_row, cursor_col,
               ref_row, ref_col);
    end
  endtask

  task automatic test_random_stream();
    int a, r, nd, fi;
    logic [7:0] b;
    do_reset();
    repeat (27) put(8'h0A);
    for (int n = 1; n <= 200; n++) begin
      r = $urandom_range(0, 99);
      if (r < 82) b = 8'($urandom_range(32, 126));
      else if (r < 90) b = 8'h0D;
      else if (r < 93) b = 8'h0A;
      else b = 8'h08;
      send(b, a);
      if ($urandom_range(0, 3) == 0) begin
        char_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge vclk);
      end
      if (n % 50 == 0) begin
        char_valid = 1'b0;
        wait_idle("rand");
        nd = scr_diffs(fi);
        nvec++;
        if (nd !== 0) begin
          nfail++;
          $display("FAIL rand_screen_%0d: %0d cells differ, first @%0d got %02h required %02h",
                   n, nd, fi, mem[fi], ref_scr[fi]);
        end
        nvec++;
        if (cursor_col !== 7'(ref_col) || cursor_row !== 5'(ref_row)) begin
          nfail++;
          $display("FAIL rand_cursor_%0d: got (%0d,%0d), required (%0d,%0d)", n, cursor_row,
                   cursor_col, ref_row, ref_col);
        end
      end
    end
    char_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_cr_lf();
    test_backspace();
    test_scroll();
    test_form_feed();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
